// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the memory access unit
package mem_pkg;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_e;
   typedef enum logic [2:0] {IDLE, RD1, RD2, WR, RESP} state_e;
   localparam int LANE_W = 2;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: lane extraction/extension for loads and lane merge for sub-word stores
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0]      i_word,
   input  logic [LANE_W-1:0] i_lane,
   input  size_e             i_size,
   input  logic              i_signed,
   input  logic [N-1:0]      i_wdata,
   output logic [N-1:0]      o_load,
   output logic [N-1:0]      o_merged
);
   logic [N-1:0] w_shift;
   logic [N-1:0] w_mask;
   // shift the addressed lane down for loads; mask the lane in for stores
   always_comb begin
      w_shift  = i_word >> {i_lane, 3'b000};
      o_load   = (i_size == SZ_BYTE) ? {{(N-8){i_signed & w_shift[7]}}, w_shift[7:0]} :
                 (i_size == SZ_HALF) ? {{(N-16){i_signed & w_shift[15]}}, w_shift[15:0]} : i_word;
      w_mask   = ((i_size == SZ_BYTE) ? N'(8'hFF) : (i_size == SZ_HALF) ? N'(16'hFFFF) : {N{1'b1}})
                 << {i_lane, 3'b000};
      o_merged = (i_word & ~w_mask) | ((i_wdata << {i_lane, 3'b000}) & w_mask);
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store front end for a word-addressed data memory
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 94500
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_req_valid,
   output logic         o_req_ready,
   input  logic         i_req_we,
   input  logic [1:0]   i_req_size,
   input  logic         i_req_signed,
   input  logic [N-1:0] i_req_addr,
   input  logic [N-1:0] i_req_wdata,
   output logic         o_resp_valid,
   input  logic         i_resp_ready,
   output logic [N-1:0] o_resp_rdata,
   output logic         o_resp_err,
   output logic         o_mem_wr,
   output logic [N-1:0] o_mem_addr,
   output logic [N-1:0] o_mem_wdata,
   input  logic [N-1:0] i_mem_rdata
);
   localparam logic [N-1:0] DEPTH_V = N'(DEPTH);
   state_e            r_state, w_next;
   size_e             w_size, r_size;
   logic              w_accept, w_err;
   logic [N-1:0]      w_widx, w_load, w_merged;
   logic              r_we, r_signed;
   logic [LANE_W-1:0] r_lane;
   logic [N-1:0]      r_wdata;
   logic              r_resp_valid, r_resp_err, r_mem_wr;
   logic [N-1:0]      r_resp_rdata, r_mem_addr, r_mem_wdata;

   assign w_size   = size_e'(i_req_size);
   assign w_widx   = {2'b00, i_req_addr[N-1:2]};
   assign w_accept = i_req_valid & o_req_ready;
   assign w_err    = (w_size == SZ_BAD) | ((w_size == SZ_HALF) & i_req_addr[0]) |
                     ((w_size == SZ_WORD) & |i_req_addr[1:0]) | (w_widx >= DEPTH_V);

   assign o_req_ready  = (r_state == IDLE);
   assign o_resp_valid = r_resp_valid;
   assign o_resp_err   = r_resp_err;
   assign o_resp_rdata = r_resp_rdata;
   assign o_mem_wr     = r_mem_wr;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wdata  = r_mem_wdata;

   mem_lane_align #(.N(N)) u_align (
      .i_word   (i_mem_rdata),
      .i_lane   (r_lane),
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_wdata  (r_wdata),
      .o_load   (w_load),
      .o_merged (w_merged)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;

   // next state: errors answer at once, word stores skip the read, sub-word stores read first
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_next = w_err ? RESP : (i_req_we & (w_size == SZ_WORD)) ? WR : RD1;
         RD1:  w_next = RD2;
         RD2:  w_next = r_we ? WR : RESP;
         WR:   w_next = RESP;
         RESP: if (i_resp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // request latches, memory interface and response registers
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_we         <= 1'b0;
         r_size       <= SZ_BYTE;
         r_signed     <= 1'b0;
         r_lane       <= '0;
         r_wdata      <= '0;
         r_mem_wr     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_mem_wr     <= (w_next == WR);
         r_resp_valid <= (w_next == RESP);
         if (w_accept) begin
            r_we       <= i_req_we;
            r_size     <= w_size;
            r_signed   <= i_req_signed;
            r_lane     <= i_req_addr[LANE_W-1:0];
            r_wdata    <= i_req_wdata;
            r_resp_err <= w_err;
            if (!w_err) r_mem_addr <= w_widx;
            if (!w_err & i_req_we & (w_size == SZ_WORD)) r_mem_wdata <= i_req_wdata;
         end
         if ((r_state == RD2) & r_we) r_mem_wdata <= w_merged;
         if ((r_state == RD2) & !r_we) r_resp_rdata <= w_load;
         if ((r_state == RESP) & i_resp_ready) begin
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
         end
      end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench with a behavioural data memory
module tb_mem_access_unit;
   localparam int DEPTH = 94500;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err, mem_wr;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] mem [0:DEPTH-1];
   int          wr_cnt = 0;
   int          n_cmp = 0, n_bad = 0;

   mem_access_unit #(.N(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
      .i_req_size(req_size), .i_req_signed(req_signed), .i_req_addr(req_addr),
      .i_req_wdata(req_wdata), .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
      .o_resp_rdata(resp_rdata), .o_resp_err(resp_err), .o_mem_wr(mem_wr),
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // memory: registered read on posedge, write on negedge
   always @(posedge clk) mem_rdata <= (mem_addr < DEPTH) ? mem[mem_addr] : 32'h0;
   always @(negedge clk) begin
      if (mem_wr) begin
         wr_cnt = wr_cnt + 1;
         if (mem_addr < DEPTH) mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output int wrs);
      int w0;
      @(negedge clk);
      req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      w0 = wr_cnt;
      @(posedge clk);
      lat = 1;
      #1;
      req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_signed = ~sg;
      req_addr = $urandom; req_wdata = $urandom;
      while (!resp_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
      end
      if (!resp_valid) lat = 0;
      wrs = wr_cnt - w0;
   endtask

   task automatic release_resp();
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({req_ready, resp_valid, resp_err, mem_wr} !== 4'b1000) begin
         n_bad++; $display("FAIL reset_flags: got %b want 1000", {req_ready, resp_valid, resp_err, mem_wr});
      end
      n_cmp++;
      if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
         n_bad++; $display("FAIL reset_data: got %h %h %h want 0", resp_rdata, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_word_store();
      int lat, wrs;
      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, wrs);
      n_cmp++;
      if (lat !== 2) begin n_bad++; $display("FAIL wst_latency: got %0d want 2", lat); end
      n_cmp++;
      if (mem_addr !== 32'd4) begin n_bad++; $display("FAIL wst_addr: got %0d want 4", mem_addr); end
      n_cmp++;
      if (wrs !== 1) begin n_bad++; $display("FAIL wst_wr_cycles: got %0d want 1", wrs); end
      n_cmp++;
      if ({resp_err, resp_rdata} !== 33'h0) begin
         n_bad++; $display("FAIL wst_resp: got err=%b rdata=%h want 0/0", resp_err, resp_rdata);
      end
      n_cmp++;
      if (mem[4] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wst_mem: got %h want deadbeef", mem[4]); end
      release_resp();
      n_cmp++;
      if ({resp_valid, resp_err, req_ready, mem_wr} !== 4'b0010) begin
         n_bad++; $display("FAIL wst_release: got %b want 0010", {resp_valid, resp_err, req_ready, mem_wr});
      end
   endtask

   task automatic test_byte_load();
      int lat, wrs;
      issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, wrs);
      n_cmp++;
      if (lat !== 3) begin n_bad++; $display("FAIL lb_latency: got %0d want 3", lat); end
      n_cmp++;
      if (resp_rdata !== 32'hFFFFFFBE) begin n_bad++; $display("FAIL lb_signed: got %h want ffffffbe", resp_rdata); end
      release_resp();
      issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, wrs);
      n_cmp++;
      if (resp_rdata !== 32'h000000BE) begin n_bad++; $display("FAIL lb_unsigned: got %h want 000000be", resp_rdata); end
      n_cmp++;
      if (wrs !== 0) begin n_bad++; $display("FAIL lb_no_write: got %0d want 0", wrs); end
      release_resp();
   endtask

   task automatic test_half_store();
      int lat, wrs;
      issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h5555A5A5, lat, wrs);
      n_cmp++;
      if (lat !== 4) begin n_bad++; $display("FAIL sh_latency: got %0d want 4", lat); end
      n_cmp++;
      if (wrs !== 1) begin n_bad++; $display("FAIL sh_wr_cycles: got %0d want 1", wrs); end
      n_cmp++;
      if (mem[4] !== 32'hA5A5BEEF) begin n_bad++; $display("FAIL sh_merge: got %h want a5a5beef", mem[4]); end
      release_resp();
      issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, wrs);
      n_cmp++;
      if (resp_rdata !== 32'h0000A5A5) begin n_bad++; $display("FAIL lh_unsigned: got %h want 0000a5a5", resp_rdata); end
      release_resp();
      issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, wrs);
      n_cmp++;
      if (resp_rdata !== 32'hFFFFA5A5) begin n_bad++; $display("FAIL lh_signed: got %h want ffffa5a5", resp_rdata); end
      release_resp();
   endtask

   task automatic test_errors();
      int lat, wrs;
      logic        we_v [3] = '{1'b0, 1'b1, 1'b1};
      logic [1:0]  sz_v [3] = '{2'b10, 2'b01, 2'b11};
      logic [31:0] ad_v [3] = '{32'h13, 32'h11, 32'h10};
      for (int i = 0; i < 3; i++) begin
         issue(we_v[i], sz_v[i], 1'b1, ad_v[i], 32'hFFFFFFFF, lat, wrs);
         n_cmp++;
         if (lat !== 1) begin n_bad++; $display("FAIL err%0d_latency: got %0d want 1", i, lat); end
         n_cmp++;
         if ({resp_err, resp_rdata} !== {1'b1, 32'h0}) begin
            n_bad++; $display("FAIL err%0d_resp: got err=%b rdata=%h want 1/0", i, resp_err, resp_rdata);
         end
         n_cmp++;
         if (wrs !== 0 || mem_addr !== 32'd4) begin
            n_bad++; $display("FAIL err%0d_nomem: got wr=%0d addr=%0d want 0/4", i, wrs, mem_addr);
         end
         release_resp();
      end
      n_cmp++;
      if (mem[4] !== 32'hA5A5BEEF) begin n_bad++; $display("FAIL err_mem_kept: got %h want a5a5beef", mem[4]); end
   endtask

   task automatic test_range();
      int lat, wrs;
      issue(1'b1, 2'b10, 1'b0, 32'd378000, 32'h11111111, lat, wrs);
      n_cmp++;
      if ({resp_err, resp_rdata} !== {1'b1, 32'h0} || lat !== 1) begin
         n_bad++; $display("FAIL range_over: got err=%b rdata=%h lat=%0d want 1/0/1", resp_err, resp_rdata, lat);
      end
      n_cmp++;
      if (wrs !== 0 || mem_addr !== 32'd4) begin
         n_bad++; $display("FAIL range_over_nomem: got wr=%0d addr=%0d want 0/4", wrs, mem_addr);
      end
      release_resp();
      issue(1'b1, 2'b10, 1'b0, 32'd377996, 32'h12345678, lat, wrs);
      n_cmp++;
      if (resp_err !== 1'b0 || lat !== 2 || mem_addr !== 32'd94499) begin
         n_bad++; $display("FAIL range_last_st: got err=%b lat=%0d addr=%0d want 0/2/94499", resp_err, lat, mem_addr);
      end
      n_cmp++;
      if (mem[DEPTH-1] !== 32'h12345678) begin n_bad++; $display("FAIL range_last_mem: got %h want 12345678", mem[DEPTH-1]); end
      release_resp();
      issue(1'b0, 2'b10, 1'b0, 32'd377996, 32'h0, lat, wrs);
      n_cmp++;
      if (resp_rdata !== 32'h12345678 || lat !== 3) begin
         n_bad++; $display("FAIL range_last_ld: got %h lat=%0d want 12345678/3", resp_rdata, lat);
      end
      release_resp();
   endtask

   task automatic test_stall();
      int lat, wrs;
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, wrs);
      n_cmp++;
      if (resp_rdata !== 32'hA5A5BEEF) begin n_bad++; $display("FAIL stall_data: got %h want a5a5beef", resp_rdata); end
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'h99999999;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if ({resp_valid, resp_err, req_ready, mem_wr} !== 4'b1000 || resp_rdata !== 32'hA5A5BEEF || mem_addr !== 32'd4) begin
            n_bad++;
            $display("FAIL stall_hold%0d: got v=%b e=%b rdy=%b wr=%b d=%h a=%0d want 1/0/0/0/a5a5beef/4",
                     i, resp_valid, resp_err, req_ready, mem_wr, resp_rdata, mem_addr);
         end
      end
      req_valid = 1'b0;
      release_resp();
      n_cmp++;
      if ({resp_valid, req_ready} !== 2'b01 || resp_rdata !== 32'h0) begin
         n_bad++; $display("FAIL stall_release: got v=%b rdy=%b d=%h want 0/1/0", resp_valid, req_ready, resp_rdata);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h00000077; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({mem_wr, resp_valid, mem_addr, mem_wdata} !== 66'h0) begin
         n_bad++; $display("FAIL rst_mid_clear: got wr=%b v=%b a=%h d=%h want 0", mem_wr, resp_valid, mem_addr, mem_wdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (mem[4] !== 32'hA5A5BEEF) begin n_bad++; $display("FAIL rst_mid_mem: got %h want a5a5beef", mem[4]); end
      n_cmp++;
      if ({resp_valid, req_ready, mem_wr} !== 3'b010) begin
         n_bad++; $display("FAIL rst_mid_idle: got %b want 010", {resp_valid, req_ready, mem_wr});
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_word_store();
      test_byte_load();
      test_half_store();
      test_errors();
      test_range();
      test_stall();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
